// File: rtl/u_imem_if.sv
// Fetch and program-loader bus for the instruction memory.
// IMEM_ERR_EN adds the registered ins_err fetch error flag.
interface u_imem_if #(
   parameter int unsigned AW    = 16,
   parameter int unsigned DEPTH = 4096
);
   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic [AW-1:0] ins_a;
   logic          ins_e;
   logic [31:0]   ins;
`ifdef IMEM_ERR_EN
   logic          ins_err;
`endif
   logic          ld_start;
   logic [AW-1:0] ld_adr;
   logic [LW-1:0] ld_len;
   logic          ld_valid;
   logic [7:0]    ld_byte;
   logic          ld_ready;
   logic          ld_busy;
   logic          ld_done;

`ifdef IMEM_ERR_EN
   modport slave (
      input  ins_a, ins_e, ld_start, ld_adr, ld_len, ld_valid, ld_byte,
      output ins, ins_err, ld_ready, ld_busy, ld_done
   );
   modport master (
      output ins_a, ins_e, ld_start, ld_adr, ld_len, ld_valid, ld_byte,
      input  ins, ins_err, ld_ready, ld_busy, ld_done
   );
`else
   modport slave (
      input  ins_a, ins_e, ld_start, ld_adr, ld_len, ld_valid, ld_byte,
      output ins, ld_ready, ld_busy, ld_done
   );
   modport master (
      output ins_a, ins_e, ld_start, ld_adr, ld_len, ld_valid, ld_byte,
      input  ins, ld_ready, ld_busy, ld_done
   );
`endif
endinterface

// File: rtl/u_imem.sv
// Instruction memory with 1-cycle registered fetch and a little-endian byte-stream loader.
// Optional IMEM_ERR_EN adds ins_err (misaligned, out-of-range or busy fetch).
module u_imem #(
   parameter int unsigned AW    = 16,
   parameter int unsigned DEPTH = 4096,
   parameter logic [31:0] NOP   = 32'h00000013
) (
   input logic     clk,
   input logic     rstn,
   u_imem_if.slave bus
);
   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned LW = IW + 1;

   typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

   state_e        state_q;
   logic [IW-1:0] wptr_q;
   logic [LW-1:0] wcnt_q;
   logic [1:0]    bcnt_q;
   logic [23:0]   asm_q;
   logic          ld_ready_q;
   logic          ld_busy_q;
   logic          ld_done_q;
   logic [31:0]   ins_q;
   logic [31:0]   mem [DEPTH];

   logic [AW-3:0] rd_idx;
   logic          rd_oor;
   logic          rd_blocked;
   logic          wr_en;
   logic [31:0]   wr_data;
   logic          unused_bits;

   assign rd_idx     = bus.ins_a[AW-1:2];
   assign rd_oor     = {1'b0, rd_idx} >= (AW-1)'(DEPTH);
   assign rd_blocked = rd_oor | ld_busy_q;
   // Gated by rstn so a 4th byte coinciding with reset is discarded.
   assign wr_en      = rstn & ld_ready_q & bus.ld_valid & (bcnt_q == 2'd3);
   assign wr_data    = {bus.ld_byte, asm_q};
   assign unused_bits = ^{bus.ins_a[1:0], bus.ld_adr};

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ins_q <= NOP;
      end else if (bus.ins_e) begin
         ins_q <= rd_blocked ? NOP : mem[rd_idx[IW-1:0]];
      end
   end

`ifdef IMEM_ERR_EN
   logic ins_err_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ins_err_q <= 1'b0;
      end else if (bus.ins_e) begin
         ins_err_q <= rd_blocked | (bus.ins_a[1:0] != 2'b00);
      end
   end

   assign bus.ins_err = ins_err_q;
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= StIdle;
         wptr_q     <= '0;
         wcnt_q     <= '0;
         bcnt_q     <= '0;
         asm_q      <= '0;
         ld_ready_q <= 1'b0;
         ld_busy_q  <= 1'b0;
         ld_done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.ld_start) begin
                  ld_busy_q <= 1'b1;
                  if (bus.ld_len != '0) begin
                     state_q    <= StLoad;
                     ld_ready_q <= 1'b1;
                     wptr_q     <= bus.ld_adr[IW+1:2];
                     wcnt_q     <= bus.ld_len;
                     bcnt_q     <= '0;
                  end else begin
                     state_q   <= StDone;
                     ld_done_q <= 1'b1;
                  end
               end
            end
            StLoad: begin
               if (bus.ld_valid) begin
                  bcnt_q <= bcnt_q + 2'd1;
                  if (bcnt_q != 2'd3) begin
                     asm_q[{bcnt_q, 3'b000} +: 8] <= bus.ld_byte;
                  end else begin
                     wptr_q <= wptr_q + IW'(1);
                     wcnt_q <= wcnt_q - LW'(1);
                     if (wcnt_q == LW'(1)) begin
                        state_q    <= StDone;
                        ld_ready_q <= 1'b0;
                        ld_done_q  <= 1'b1;
                     end
                  end
               end
            end
            StDone: begin
               state_q   <= StIdle;
               ld_busy_q <= 1'b0;
               ld_done_q <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.ins      = ins_q;
   assign bus.ld_ready = ld_ready_q;
   assign bus.ld_busy  = ld_busy_q;
   assign bus.ld_done  = ld_done_q;
endmodule

// File: tb/tb_u_imem.sv
// Self-checking bench for u_imem: vector tables, hand sequences and randomized loads/fetches.
// Checks ins_err as well when built with IMEM_ERR_EN.
module tb_u_imem;
   localparam int unsigned AW    = 16;
   localparam int unsigned DEPTH = 4096;
   localparam int unsigned LW    = 13;
   localparam logic [31:0] NOP   = 32'h00000013;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   u_imem_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

   u_imem #(.AW(AW), .DEPTH(DEPTH), .NOP(NOP)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] model_mem [DEPTH];
   bit          written   [DEPTH];
   int          wlist[$];

   typedef struct {
      logic [AW-1:0] adr;
      logic [LW-1:0] len;
      logic [31:0]   w0;
      logic [31:0]   w1;
      int            mode;
      int            i0;
      int            i1;
      int            nread;
   } load_vec_t;

   typedef struct {
      logic          e;
      logic [AW-1:0] a;
      logic [31:0]   ins;
      logic          err;
   } fetch_vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_write(input int idx, input logic [31:0] w);
      model_mem[idx] = w;
      if (!written[idx]) wlist.push_back(idx);
      written[idx] = 1'b1;
   endtask

   task automatic fetch(input logic e, input logic [AW-1:0] a);
      bus.ins_e = e;
      bus.ins_a = a;
      step();
   endtask

   // mode 0: continuous valid, 1: valid toggles, 2: random valid plus ignored ld_start noise
   task automatic do_load(input logic [AW-1:0] adr, input logic [LW-1:0] len,
                          input logic [31:0] words[$], input int mode, input string tag);
      int          nbytes, k, cyc;
      bit          busy_ok, early_done;
      logic        v, rdy;
      logic [31:0] w;
      bus.ld_adr   = adr;
      bus.ld_len   = len;
      bus.ld_start = 1'b1;
      step();
      bus.ld_start = 1'b0;
      nbytes = int'(len) * 4;
      k = 0; cyc = 0; busy_ok = 1'b1; early_done = 1'b0;
      while (k < nbytes && cyc < 4000) begin
         if (!bus.ld_busy) busy_ok = 1'b0;
         if (bus.ld_done) early_done = 1'b1;
         case (mode)
            0:       v = 1'b1;
            1:       v = (cyc % 2 == 0);
            default: v = ($urandom_range(0, 2) != 0);
         endcase
         if (mode == 2) begin
            bus.ld_start = 1'($urandom_range(0, 1));
            bus.ld_adr   = AW'($urandom);
         end
         w = words[k / 4];
         bus.ld_valid = v;
         bus.ld_byte  = w[8 * (k % 4) +: 8];
         rdy = bus.ld_ready;
         step();
         if (v && rdy) k++;
         cyc++;
      end
      bus.ld_valid = 1'b0;
      bus.ld_start = 1'b0;
      check({tag, ":bytes_accepted"}, k, nbytes);
      check({tag, ":busy_during_load"}, busy_ok, 1);
      check({tag, ":no_early_done"}, early_done, 0);
      check({tag, ":done_pulse"}, bus.ld_done, 1);
      check({tag, ":ready_low_in_done"}, bus.ld_ready, 0);
      check({tag, ":busy_in_done"}, bus.ld_busy, 1);
      step();
      check({tag, ":done_single"}, bus.ld_done, 0);
      check({tag, ":idle_not_busy"}, bus.ld_busy, 0);
      for (int i = 0; i < int'(len); i++) begin
         model_write((int'(adr[AW-1:2]) + i) % DEPTH, words[i]);
      end
   endtask

   load_vec_t   lv [4];
   fetch_vec_t  fv [10];
   logic [31:0] q[$];
   logic [31:0] wa, wb, exp_ins;
   logic [AW-1:0] ra;
   logic        re, exp_err, known, err_known;
   int          idx;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      lv[0] = '{16'h0010, 13'd2, 32'h00500013, 32'h00100093, 0, 4, 5, 2};
      lv[1] = '{16'h0020, 13'd2, 32'h00500013, 32'h00100093, 1, 8, 9, 2};
      lv[2] = '{16'h3FFC, 13'd2, 32'hDEADBEEF, 32'h12345678, 0, 4095, 0, 2};
      lv[3] = '{16'h0010, 13'd0, 32'h00500013, 32'h00000000, 0, 4, 0, 1};

      fv[0] = '{1'b1, 16'h0010, 32'h00500013, 1'b0};
      fv[1] = '{1'b1, 16'h0014, 32'h00100093, 1'b0};
      fv[2] = '{1'b1, 16'h3FFC, 32'hDEADBEEF, 1'b0};
      fv[3] = '{1'b1, 16'h0000, 32'h12345678, 1'b0};
      fv[4] = '{1'b1, 16'h4000, NOP,          1'b1};
      fv[5] = '{1'b0, 16'h0010, NOP,          1'b1};
      fv[6] = '{1'b1, 16'h0002, 32'h12345678, 1'b1};
      fv[7] = '{1'b1, 16'h0024, 32'h00100093, 1'b0};
      fv[8] = '{1'b0, 16'h0012, 32'h00100093, 1'b0};
      fv[9] = '{1'b1, 16'hFFFC, NOP,          1'b1};

      bus.ins_e = 1'b1; bus.ins_a = '0; bus.ld_start = 1'b0; bus.ld_adr = '0;
      bus.ld_len = '0; bus.ld_valid = 1'b0; bus.ld_byte = '0;

      // Reset
      rstn = 1'b0;
      step();
      step();
      check("rst:ins", bus.ins, NOP);
      check("rst:ld_ready", bus.ld_ready, 0);
      check("rst:ld_busy", bus.ld_busy, 0);
      check("rst:ld_done", bus.ld_done, 0);
`ifdef IMEM_ERR_EN
      check("rst:ins_err", bus.ins_err, 0);
`endif
      bus.ins_e = 1'b0;
      rstn = 1'b1;
      step();

      // Load vectors with readback
      for (int i = 0; i < 4; i++) begin
         q = {};
         q.push_back(lv[i].w0);
         q.push_back(lv[i].w1);
         do_load(lv[i].adr, lv[i].len, q, lv[i].mode, $sformatf("load%0d", i));
         fetch(1'b1, AW'(lv[i].i0 * 4));
         check($sformatf("load%0d:read0", i), bus.ins, lv[i].w0);
         if (lv[i].nread > 1) begin
            fetch(1'b1, AW'(lv[i].i1 * 4));
            check($sformatf("load%0d:read1", i), bus.ins, lv[i].w1);
         end
         bus.ins_e = 1'b0;
      end

      // Fetch vectors
      for (int i = 0; i < 10; i++) begin
         fetch(fv[i].e, fv[i].a);
         check($sformatf("fetch%0d:ins", i), bus.ins, fv[i].ins);
`ifdef IMEM_ERR_EN
         check($sformatf("fetch%0d:ins_err", i), bus.ins_err, fv[i].err);
`endif
      end

      // Fetch while busy returns NOP
      wa = 32'h0BADC0DE;
      bus.ins_e = 1'b0;
      bus.ld_adr = 16'h0200; bus.ld_len = 13'd1; bus.ld_start = 1'b1;
      step();
      bus.ld_start = 1'b0;
      fetch(1'b1, 16'h0010);
      check("busy:ins_nop", bus.ins, NOP);
`ifdef IMEM_ERR_EN
      check("busy:ins_err", bus.ins_err, 1);
`endif
      bus.ins_e = 1'b0;
      for (int b = 0; b < 4; b++) begin
         bus.ld_valid = 1'b1;
         bus.ld_byte  = wa[8 * b +: 8];
         step();
      end
      bus.ld_valid = 1'b0;
      check("busy:done_pulse", bus.ld_done, 1);
      step();
      model_write(128, wa);
      fetch(1'b1, 16'h0200);
      check("busy:readback", bus.ins, wa);
      bus.ins_e = 1'b0;

      // Reset in the middle of a two-word load
      q = {32'hCAFEF00D};
      do_load(16'h0104, 13'd1, q, 0, "pre");
      wa = 32'hA1B2C3D4;
      wb = 32'h55667788;
      bus.ld_adr = 16'h0100; bus.ld_len = 13'd2; bus.ld_start = 1'b1;
      step();
      bus.ld_start = 1'b0;
      for (int b = 0; b < 6; b++) begin
         bus.ld_valid = 1'b1;
         bus.ld_byte  = (b < 4) ? wa[8 * b +: 8] : wb[8 * (b - 4) +: 8];
         step();
      end
      bus.ld_valid = 1'b0;
      rstn = 1'b0;
      step();
      check("midrst:busy", bus.ld_busy, 0);
      check("midrst:ready", bus.ld_ready, 0);
      check("midrst:done", bus.ld_done, 0);
      rstn = 1'b1;
      step();
      check("midrst:no_done_after", bus.ld_done, 0);
      check("midrst:idle", bus.ld_busy, 0);
      model_write(64, wa);
      fetch(1'b1, 16'h0100);
      check("midrst:word0_written", bus.ins, wa);
      fetch(1'b1, 16'h0104);
      check("midrst:word1_kept", bus.ins, 32'hCAFEF00D);
      bus.ins_e = 1'b0;

      // Random loads with random stalls
      for (int n = 0; n < 15; n++) begin
         q = {};
         idx = $urandom_range(1, 4);
         for (int i = 0; i < idx; i++) q.push_back($urandom);
         do_load(AW'($urandom), LW'(idx), q, 2, $sformatf("rload%0d", n));
      end

      // Random fetches against the memory model
      known = 1'b0; err_known = 1'b0; exp_ins = NOP; exp_err = 1'b0;
      for (int n = 0; n < 300; n++) begin
         re = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1)
            ra = AW'(wlist[$urandom_range(0, wlist.size() - 1)] * 4 + $urandom_range(0, 3));
         else
            ra = AW'($urandom);
         if (re) begin
            idx = int'(ra) / 4;
            exp_err = (ra % 4 != 0) || (idx >= DEPTH);
            err_known = 1'b1;
            if (idx >= DEPTH) begin
               exp_ins = NOP; known = 1'b1;
            end else if (written[idx]) begin
               exp_ins = model_mem[idx]; known = 1'b1;
            end else begin
               known = 1'b0;
            end
         end
         fetch(re, ra);
         if (known) check($sformatf("rfetch%0d:ins", n), bus.ins, exp_ins);
`ifdef IMEM_ERR_EN
         if (err_known) check($sformatf("rfetch%0d:ins_err", n), bus.ins_err, exp_err);
`endif
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
